// File: rtl/stream2wb_pkg.sv
// Shared definitions for the byte-stream to Wishbone burst bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: command opcodes, status byte codes and the bridge state encoding.
package stream2wb_pkg;

  // Command byte bits [7:6].
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_AUX   = 2'b11
  } op_e;

  // Status byte closing every WRITE/READ command.
  localparam logic [7:0] STAT_OK        = 8'h00;
  localparam logic [7:0] STAT_TIMEOUT   = 8'h01;
  localparam logic [7:0] STAT_BAD_SLAVE = 8'h02;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_ADDR,
    ST_HDR_CNT,
    ST_WR_DATA,
    ST_WB_ACC,
    ST_RD_SEND,
    ST_STATUS,
    ST_DRAIN,
    ST_AUX_DATA
  } state_e;

endpackage

// File: rtl/stream2wb_timeout.sv
// Loadable down-counter used as the Wishbone ack watchdog.
// Latency: load takes effect next cycle; expired_o is combinational on the count.
// Backpressure: none; counts down only while en_i is high and saturates at zero.
// Ports: clk/rst (sync, active-high), load_i + load_val_i load the count,
//        en_i enables decrement, expired_o is high while the count is zero.
module stream2wb_timeout #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/stream2wb_burst.sv
// Host byte-stream command bridge to up to 16 Wishbone slaves (burst write/read, AUX CSR).
// Latency: one Wishbone access per word, wb_cyc drops the cycle after ack; bytes move one per cycle.
// Backpressure: rx_ready/tx_valid follow the FSM; tx bytes hold while tx_ready is low; ack watchdog aborts.
// Ports: clk, rst (sync active-high); rx_data/rx_valid/rx_ready host->bridge bytes;
//        tx_data/tx_last/tx_valid/tx_ready bridge->host bytes; wb_addr/wb_wdata/wb_we shared,
//        wb_cyc one-hot per slave, wb_ack/wb_rdata per slave; aux_csr host register; busy = not IDLE.
module stream2wb_burst
  import stream2wb_pkg::*;
#(
  parameter int WB_N      = 1,
  parameter int ADDR_W    = 16,
  parameter int TO_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_last,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [ADDR_W-1:0]    wb_addr,
  output logic [31:0]          wb_wdata,
  output logic                 wb_we,
  output logic [WB_N-1:0]      wb_cyc,
  input  logic [WB_N-1:0]      wb_ack,
  input  logic [32*WB_N-1:0]   wb_rdata,
  output logic [31:0]          aux_csr,
  output logic                 busy
);

  localparam int         AW_BYTES = ADDR_W / 8;
  localparam logic [1:0] HDR_LAST = 2'(AW_BYTES - 1);
  localparam int         TW       = $clog2(TO_CYCLES);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic                inc_q, inc_d;
  logic [3:0]          slv_q, slv_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          cnt_q, cnt_d;     // words still to go after the current one
  logic [1:0]          byte_q, byte_d;   // byte position within a 32-bit word
  logic [1:0]          hdr_q, hdr_d;     // address byte position
  logic [31:0]         data_q, data_d;   // write word, read word being sent, AUX staging
  logic [10:0]         drain_q, drain_d; // bytes left to discard
  logic [7:0]          status_q, status_d;
  logic [31:0]         aux_q, aux_d;

  logic        rx_fire, tx_fire;
  logic        ack_sel, bad_slv, in_acc;
  logic [31:0] rdata_sel;
  logic        tmr_load, tmr_expired;

  // Watchdog: loaded with TO_CYCLES-1 on entry to WB_ACC so wb_cyc is held for
  // exactly TO_CYCLES cycles; an ack in the last of those still wins.
  stream2wb_timeout #(.W(TW)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (TW'(TO_CYCLES - 1)),
    .en_i       (in_acc),
    .expired_o  (tmr_expired)
  );

  assign in_acc  = (state_q == ST_WB_ACC);
  assign bad_slv = (32'(slv_q) >= 32'(WB_N));

  // Only the addressed slave's ack/rdata are looked at; others are ignored.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    wb_cyc    = '0;
    for (int i = 0; i < WB_N; i++) begin
      if (slv_q == 4'(i)) begin
        ack_sel   = wb_ack[i];
        rdata_sel = wb_rdata[32*i +: 32];
        wb_cyc[i] = in_acc;
      end
    end
  end

  assign rx_ready = !rst && ((state_q == ST_IDLE)    || (state_q == ST_HDR_ADDR) ||
                             (state_q == ST_HDR_CNT) || (state_q == ST_WR_DATA)  ||
                             (state_q == ST_DRAIN)   || (state_q == ST_AUX_DATA));
  assign tx_valid = (state_q == ST_RD_SEND) || (state_q == ST_STATUS);
  assign tx_last  = (state_q == ST_STATUS);
  assign tx_data  = (state_q == ST_STATUS) ? status_q : data_q[31:24];
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign busy     = (state_q != ST_IDLE);
  assign wb_addr  = addr_q;
  assign wb_wdata = data_q;
  assign wb_we    = in_acc && we_q;
  assign aux_csr  = aux_q;
  assign tmr_load = (state_d == ST_WB_ACC) && (state_q != ST_WB_ACC);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    inc_d    = inc_q;
    slv_d    = slv_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    hdr_d    = hdr_q;
    data_d   = data_q;
    drain_d  = drain_q;
    status_d = status_q;
    aux_d    = aux_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          byte_d = '0;
          hdr_d  = '0;
          inc_d  = rx_data[5];
          slv_d  = rx_data[3:0];
          case (op_e'(rx_data[7:6]))
            OP_WRITE: begin we_d = 1'b1; state_d = ST_HDR_ADDR; end
            OP_READ:  begin we_d = 1'b0; state_d = ST_HDR_ADDR; end
            OP_AUX:   state_d = ST_AUX_DATA;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_HDR_ADDR: begin
        if (rx_fire) begin
          addr_d = ADDR_W'({addr_q, rx_data});
          hdr_d  = hdr_q + 2'd1;
          if (hdr_q == HDR_LAST) state_d = ST_HDR_CNT;
        end
      end
      ST_HDR_CNT: begin
        if (rx_fire) begin
          cnt_d  = rx_data;
          byte_d = '0;
          if (bad_slv) begin
            status_d = STAT_BAD_SLAVE;
            if (we_q) begin
              // Swallow all 4*(C+1) payload bytes to stay in step with the host.
              drain_d = 11'(({3'b000, rx_data} + 11'd1) << 2);
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_STATUS;
            end
          end else begin
            status_d = STAT_OK;
            state_d  = we_q ? ST_WR_DATA : ST_WB_ACC;
          end
        end
      end
      ST_WR_DATA: begin
        if (rx_fire) begin
          data_d = {data_q[23:0], rx_data};
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) state_d = ST_WB_ACC;
        end
      end
      ST_WB_ACC: begin
        if (ack_sel) begin
          if (inc_q) addr_d = addr_q + 1'b1;
          if (we_q) begin
            if (cnt_q == 8'd0) begin
              state_d = ST_STATUS;
            end else begin
              cnt_d   = cnt_q - 8'd1;
              state_d = ST_WR_DATA;
            end
          end else begin
            data_d  = rdata_sel;
            state_d = ST_RD_SEND;
          end
        end else if (tmr_expired) begin
          status_d = STAT_TIMEOUT;
          if (we_q && (cnt_q != 8'd0)) begin
            drain_d = {1'b0, cnt_q, 2'b00};
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_STATUS;
          end
        end
      end
      ST_RD_SEND: begin
        if (tx_fire) begin
          data_d = {data_q[23:0], 8'h00};
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            if (cnt_q == 8'd0) begin
              state_d = ST_STATUS;
            end else begin
              cnt_d   = cnt_q - 8'd1;
              state_d = ST_WB_ACC;
            end
          end
        end
      end
      ST_STATUS: begin
        if (tx_fire) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (rx_fire) begin
          drain_d = drain_q - 11'd1;
          if (drain_q == 11'd1) state_d = ST_STATUS;
        end
      end
      ST_AUX_DATA: begin
        if (rx_fire) begin
          data_d = {data_q[23:0], rx_data};
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            aux_d   = {data_q[23:0], rx_data};
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      inc_q    <= 1'b0;
      slv_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      byte_q   <= '0;
      hdr_q    <= '0;
      data_q   <= '0;
      drain_q  <= '0;
      status_q <= '0;
      aux_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      inc_q    <= inc_d;
      slv_q    <= slv_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      hdr_q    <= hdr_d;
      data_q   <= data_d;
      drain_q  <= drain_d;
      status_q <= status_d;
      aux_q    <= aux_d;
    end
  end

endmodule

// File: tb/tb_stream2wb_burst.sv
// Directed bench for stream2wb_burst with WB_N=2, ADDR_W=16, TO_CYCLES=16.
module tb_stream2wb_burst;

  localparam int WB_N      = 2;
  localparam int ADDR_W    = 16;
  localparam int TO_CYCLES = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic [7:0]          tx_data;
  logic                tx_last;
  logic                tx_valid;
  logic                tx_ready;
  logic [ADDR_W-1:0]   wb_addr;
  logic [31:0]         wb_wdata;
  logic                wb_we;
  logic [WB_N-1:0]     wb_cyc;
  logic [WB_N-1:0]     wb_ack;
  logic [32*WB_N-1:0]  wb_rdata;
  logic [31:0]         aux_csr;
  logic                busy;

  always #5 clk = ~clk;

  stream2wb_burst #(.WB_N(WB_N), .ADDR_W(ADDR_W), .TO_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_ack(wb_ack), .wb_rdata(wb_rdata),
    .aux_csr(aux_csr), .busy(busy)
  );

  // Slave models: ack after ack_dly cycles of wb_cyc; slave 1 can be forced to
  // ack continuously to show that unselected acks are ignored.
  logic [WB_N-1:0] ack_en;
  logic            force_ack1;
  int              ack_dly;
  int              cyc_cnt [WB_N];
  logic [31:0]     rd_vals [4];
  logic [1:0]      rd_cnt = 2'd0;
  int              cyc_total = 0;
  logic [50:0]     logq [$];   // {cyc, we, addr, wdata} of every acked access
  logic [8:0]      txq  [$];   // {last, data} of every tx transfer
  logic [7:0]      pkt  [$];

  int checks = 0;
  int errors = 0;

  assign wb_ack[0] = wb_cyc[0] && ack_en[0] && (cyc_cnt[0] >= ack_dly);
  assign wb_ack[1] = (wb_cyc[1] && ack_en[1] && (cyc_cnt[1] >= ack_dly)) || force_ack1;
  assign wb_rdata  = {32'hDEAD0001, rd_vals[rd_cnt]};

  always @(posedge clk) begin
    for (int i = 0; i < WB_N; i++) cyc_cnt[i] <= wb_cyc[i] ? cyc_cnt[i] + 1 : 0;
    if (|wb_cyc) cyc_total <= cyc_total + 1;
    if (|(wb_cyc & wb_ack)) begin
      logq.push_back({wb_cyc, wb_we, wb_addr, wb_wdata});
      if (wb_cyc[0] && !wb_we) rd_cnt <= rd_cnt + 2'd1;
    end
    if (tx_valid && tx_ready) txq.push_back({tx_last, tx_data});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", 64'(n < 500), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (txq.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("tx_count", 64'(txq.size()), 64'(n));
  endtask

  task automatic count_cyc0(output int c);
    c = 0;
    while (wb_cyc[0] && c < 200) begin
      c++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          lb, tb0, c0, nc, k;
    logic [50:0] e;
    logic [8:0]  exp_rd [9];

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    ack_en = 2'b11; force_ack1 = 1'b0; ack_dly = 0;
    for (int i = 0; i < 4; i++) rd_vals[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_tx", 64'({tx_valid, tx_last}), 64'd0);
    chk("rst_busy_cyc_we", 64'({busy, wb_cyc, wb_we}), 64'd0);
    chk("rst_addr_wdata", 64'({wb_addr, wb_wdata}), 64'd0);
    chk("rst_aux", 64'(aux_csr), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", 64'(rx_ready), 64'd1);

    // NOP: consumed, nothing else
    send_byte(8'h00);
    chk("nop_busy", 64'(busy), 64'd0);
    chk("nop_tx", 64'(txq.size()), 64'd0);

    // AUX load
    pkt = '{8'hC0, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt();
    chk("aux_csr", 64'(aux_csr), 64'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("aux_no_tx", 64'(txq.size()), 64'd0);
    chk("aux_no_wb", 64'(logq.size()), 64'd0);

    // WRITE INC S=1 addr 0x0010 C=1
    lb = logq.size(); tb0 = txq.size();
    pkt = '{8'h61, 8'h00, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt();
    wait_tx(tb0 + 1);
    chk("wr_nacc", 64'(logq.size()), 64'(lb + 2));
    chk("wr_acc0", 64'(logq[lb]),     {13'd0, 2'b10, 1'b1, 16'h0010, 32'h11223344});
    chk("wr_acc1", 64'(logq[lb + 1]), {13'd0, 2'b10, 1'b1, 16'h0011, 32'h55667788});
    chk("wr_status", 64'(txq[tb0]), 64'h100);

    // READ INC S=0 addr 0xFFFF C=1, address wraps to 0
    rd_vals[rd_cnt] = 32'hA5A5A5A5;
    rd_vals[rd_cnt + 2'd1] = 32'h01020304;
    lb = logq.size(); tb0 = txq.size();
    pkt = '{8'hA0, 8'hFF, 8'hFF, 8'h01};
    send_pkt();
    wait_tx(tb0 + 9);
    exp_rd = '{9'h0A5, 9'h0A5, 9'h0A5, 9'h0A5, 9'h001, 9'h002, 9'h003, 9'h004, 9'h100};
    for (int i = 0; i < 9; i++) chk($sformatf("rd_byte%0d", i), 64'(txq[tb0 + i]), 64'(exp_rd[i]));
    e = logq[lb];
    chk("rd_acc0", 64'(e[50:32]), 64'({2'b01, 1'b0, 16'hFFFF}));
    e = logq[lb + 1];
    chk("rd_acc1", 64'(e[50:32]), 64'({2'b01, 1'b0, 16'h0000}));

    // READ timeout, slave 1 acking constantly must be ignored
    ack_en = 2'b10; force_ack1 = 1'b1;
    lb = logq.size(); tb0 = txq.size();
    pkt = '{8'h80, 8'h00, 8'h00, 8'h00};
    send_pkt();
    count_cyc0(nc);
    chk("to_cyc_len", 64'(nc), 64'd16);
    force_ack1 = 1'b0;
    wait_tx(tb0 + 1);
    chk("to_status", 64'(txq[tb0]), 64'h101);
    chk("to_no_acc", 64'(logq.size()), 64'(lb));

    // Ack in the last allowed cycle counts as success
    ack_en = 2'b01; ack_dly = 15;
    rd_vals[rd_cnt] = 32'hCAFEF00D;
    lb = logq.size(); tb0 = txq.size();
    pkt = '{8'h80, 8'h12, 8'h34, 8'h00};
    send_pkt();
    count_cyc0(nc);
    chk("lim_cyc_len", 64'(nc), 64'd16);
    wait_tx(tb0 + 5);
    chk("lim_byte0", 64'(txq[tb0]), 64'h0CA);
    chk("lim_status", 64'(txq[tb0 + 4]), 64'h100);
    e = logq[lb];
    chk("lim_addr", 64'(e[47:32]), 64'h1234);
    ack_dly = 0;

    // WRITE C=1 timing out on first word: remaining 4 bytes drained
    ack_en = 2'b10;
    lb = logq.size(); tb0 = txq.size();
    pkt = '{8'h40, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_pkt();
    wait_tx(tb0 + 1);
    chk("wto_status", 64'(txq[tb0]), 64'h101);
    chk("wto_no_acc", 64'(logq.size()), 64'(lb));

    // Bad slave WRITE: no cycle, 4 bytes drained, status 0x02
    ack_en = 2'b11;
    c0 = cyc_total; tb0 = txq.size();
    pkt = '{8'h45, 8'h00, 8'h20, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt();
    wait_tx(tb0 + 1);
    chk("bad_wr_status", 64'(txq[tb0]), 64'h102);
    chk("bad_wr_no_cyc", 64'(cyc_total), 64'(c0));

    // Bad slave READ: only the status byte
    tb0 = txq.size();
    pkt = '{8'h85, 8'h00, 8'h00, 8'h03};
    send_pkt();
    wait_tx(tb0 + 1);
    repeat (10) @(negedge clk);
    chk("bad_rd_only_status", 64'(txq.size()), 64'(tb0 + 1));
    chk("bad_rd_status", 64'(txq[tb0]), 64'h102);
    chk("bad_rd_no_cyc", 64'(cyc_total), 64'(c0));

    // READ C=3 with toggling tx_ready, reset after 6 bytes
    rd_vals[rd_cnt] = 32'h11121314;
    rd_vals[rd_cnt + 2'd1] = 32'h21222324;
    rd_vals[rd_cnt + 2'd2] = 32'h31323334;
    rd_vals[rd_cnt + 2'd3] = 32'h41424344;
    tx_ready = 1'b0;
    tb0 = txq.size();
    pkt = '{8'hA0, 8'h01, 8'h00, 8'h03};
    send_pkt();
    k = 0;
    while (txq.size() < tb0 + 6 && k < 500) begin
      tx_ready = ~tx_ready;
      @(negedge clk);
      k++;
    end
    tx_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ntx", 64'(txq.size()), 64'(tb0 + 6));
    chk("mid_rst_byte5", 64'(txq[tb0 + 5]), 64'h022);
    chk("mid_rst_tx", 64'({tx_valid, tx_last}), 64'd0);
    chk("mid_rst_rx_busy", 64'({rx_ready, busy}), 64'd0);
    chk("mid_rst_wb", 64'({wb_cyc, wb_we, wb_addr}), 64'd0);
    chk("mid_rst_wdata_aux", 64'({wb_wdata, aux_csr}), 64'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_no_tx", 64'(txq.size()), 64'(tb0 + 6));
    chk("post_rst_idle", 64'({rx_ready, busy}), 64'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream2wb_burst.md
STREAM2WB_BURST -- requirements
Module: stream2wb_burst

Interface
REQ-001 Parameter WB_N, 1: number of Wishbone slave ports (1..16).
REQ-002 Parameter ADDR_W, 16: Wishbone word-address width, multiple of 8, 8..32.
REQ-003 Parameter TO_CYCLES, 1024: ack-timeout limit in clk cycles, >= 2.
REQ-004 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rx_data / rx_valid / rx_ready  in / in / out  8 / 1 / 1  host-to-bridge byte stream.
REQ-007 tx_data / tx_last / tx_valid / tx_ready  out / out / out / in  8 / 1 / 1 / 1  bridge-to-host byte stream.
REQ-008 wb_addr  out  ADDR_W; wb_wdata  out  32; wb_we  out  1.
REQ-009 wb_cyc  out  WB_N, one-hot; wb_ack  in  WB_N; wb_rdata  in  32*WB_N, slave i on bits [32i+31:32i].
REQ-010 aux_csr  out  32  host-writable control register; busy  out  1  high whenever state is not IDLE.

Function
REQ-011 Byte transfer SHALL occur only on a cycle with valid and ready both high; multi-byte fields SHALL be MSB first.
REQ-012 Command byte: [7:6] op (00 NOP, 01 WRITE, 10 READ, 11 AUX), [5] INC, [4] reserved, [3:0] slave index S.
REQ-013 WRITE/READ header SHALL be command, ADDR_W/8 address bytes, then count byte C; burst length N = C+1 (1..256 words).
REQ-014 AUX SHALL be command plus 4 data bytes, loaded into aux_csr after the 4th byte; no response.
REQ-015 NOP SHALL be consumed with no response and no other effect.
REQ-016 States: IDLE, HDR_ADDR, HDR_CNT, WR_DATA, WB_ACC, RD_SEND, STATUS, DRAIN, AUX_DATA.
REQ-017 WRITE: per word, collect 4 bytes in WR_DATA, then WB_ACC asserts wb_cyc[S], wb_we=1 until ack.
REQ-018 READ: per word, WB_ACC asserts wb_cyc[S], wb_we=0; on ack latch the slave's word, then RD_SEND emits its 4 bytes with tx_last=0.
REQ-019 wb_cyc SHALL deassert the cycle after the ack is sampled; ack on a non-selected slave SHALL be ignored.
REQ-020 wb_addr SHALL increment by 1 per word when INC=1, modulo 2^ADDR_W (wrap to 0); constant when INC=0.
REQ-021 After the last word, STATUS SHALL emit one status byte with tx_last=1: 0x00 OK, 0x01 timeout, 0x02 bad slave.
REQ-022 S >= WB_N: no Wishbone cycle; WRITE enters DRAIN to discard 4*N bytes, READ emits no data; then status 0x02.
REQ-023 An access without ack for TO_CYCLES cycles SHALL drop wb_cyc and abort: WRITE drains the remaining data bytes, READ sends no further data; then status 0x01.
REQ-024 rx_ready SHALL be high only in IDLE, HDR_ADDR, HDR_CNT, WR_DATA, DRAIN, AUX_DATA.
REQ-025 tx_valid SHALL be high only in RD_SEND and STATUS; tx_data/tx_last SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-026 Ack arriving in the same cycle as the timeout limit SHALL be treated as success.
REQ-027 Commands SHALL be processed strictly in order; the next command byte is accepted only after the prior status byte is transferred.

Reset
REQ-028 On rst: state IDLE, wb_cyc=0, wb_we=0, wb_addr=0, wb_wdata=0, aux_csr=0, tx_valid=0, tx_last=0, rx_ready=0, busy=0, counters cleared.
REQ-029 rst mid-burst SHALL abort immediately with no status byte; partially received bytes are lost.

Structure
REQ-030 Opcode values, status codes and the state enumeration SHALL live in a shared package stream2wb_pkg.
REQ-031 One sub-module, stream2wb_timeout (loadable down-counter with expire flag), is natural; all else is inline.

Verification
REQ-032 WB_N=2, AUX 0xC0 DE AD BE EF -> aux_csr=0xDEADBEEF, no tx bytes.
REQ-033 WRITE INC S=1 addr 0x0010 C=1, data 0x11223344, 0x55667788 -> slave 1 writes at 0x0010, 0x0011; tx 0x00 with last.
REQ-034 READ INC S=0 addr 0xFFFF C=1, rdata 0xA5A5A5A5 then 0x01020304 -> addrs 0xFFFF, 0x0000; tx A5 A5 A5 A5 01 02 03 04, then 0x00 with last.
REQ-035 READ S=0 C=0, slave never acks, TO_CYCLES=16 -> wb_cyc drops after 16 cycles; tx 0x01 with last only.
REQ-036 WRITE S=5 with WB_N=2, C=0 plus 4 data bytes -> no wb_cyc, 4 bytes drained, tx 0x02 with last.
REQ-037 READ C=3 with tx_ready toggling every cycle, rst asserted after 6 bytes -> all outputs at reset values next cycle, no status byte emitted.
